// File: rtl/pmod_dac_pkg.sv
// Shared definitions for the dual-channel Pmod DAC transmitter:
// frame geometry, power-down codes and the transmitter state encoding.
package pmod_dac_pkg;

    localparam int FRAME_W   = 16;
    localparam int DATA_W    = 12;
    localparam int PD_W      = 2;
    localparam int BIT_CNT_W = 4;

    // Power-down codes carried in frame bits [13:12].
    localparam logic [PD_W-1:0] PD_NORMAL = 2'b00;
    localparam logic [PD_W-1:0] PD_1K     = 2'b01;
    localparam logic [PD_W-1:0] PD_100K   = 2'b10;
    localparam logic [PD_W-1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    // Frame layout, MSB first: two don't-care zeros, power-down code, sample.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [PD_W-1:0]   pd,
        input logic [DATA_W-1:0] data
    );
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/pmod_dac_tx_if.sv
// Sample-side handshake between the tone generator and the DAC transmitter.
// The producer uses the master modport, the transmitter the slave modport.
interface pmod_dac_tx_if
    import pmod_dac_pkg::*;
;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [PD_W-1:0]   pd;
    logic              done;

    modport master (
        output valid,
        output data_a,
        output data_b,
        output pd,
        input  ready,
        input  done
    );

    modport slave (
        input  valid,
        input  data_a,
        input  data_b,
        input  pd,
        output ready,
        output done
    );

endinterface

// File: rtl/pmod_dac_clkgen.sv
// SCLK generator: divides board_clk by CLK_DIV per half-period and emits
// one-cycle rise/fall enables for the edge the registered SCLK is about to
// take. While disabled it parks in the idle phase (SCLK high, counter 0).
module pmod_dac_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic board_clk,
    input  logic reset,
    input  logic en_i,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sclk_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    // Half-period counter and SCLK toggle; ticks mark the edge that follows.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        div_cnt_d   = div_cnt_q;
        sclk_d      = sclk_q;
        wrap        = en_i && (div_cnt_q == DIV_LAST);
        rise_tick_o = wrap && !sclk_q;
        fall_tick_o = wrap && sclk_q;

        if (!en_i) begin
            div_cnt_d = '0;
            sclk_d    = 1'b1;
        end else if (wrap) begin
            div_cnt_d = '0;
            sclk_d    = ~sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Divider state register; SCLK idles high out of reset.
    always_ff @(posedge board_clk or posedge reset) begin
        // NOTE: reset appears in the sensitivity list so it acts without a
        // clock edge; state updates use <= so all flops sample together.
        if (reset) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/pmod_dac_tx.sv
// Dual-channel serial transmitter for the 12-bit two-channel Pmod DAC.
// Accepts a sample pair on valid/ready, then shifts two 16-bit frames out
// in parallel on DINA/DINB under a shared SYNC/SCLK, followed by a SYNC-high
// gap of 2*CLK_DIV cycles before the next pair can be accepted.
module pmod_dac_tx
    import pmod_dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                board_clk,
    input  logic                reset,
    pmod_dac_tx_if.slave        bus,
    output logic                dac_sync,
    output logic                dac_sclk,
    output logic                dac_dina,
    output logic                dac_dinb
);

    localparam int GAP_W = $clog2(2 * CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pmod_dac_tx: CLK_DIV must be at least 1");
    end

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   sh_a_q, sh_a_d;
    logic [FRAME_W-1:0]   sh_b_q, sh_b_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 last_fall_q, last_fall_d;
    logic                 sync_q, sync_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic                 clk_en;
    logic                 rise_tick;
    logic                 fall_tick;

    // SCLK runs only while a frame is being shifted.
    assign clk_en = (state_q == SHIFT);

    pmod_dac_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .board_clk   (board_clk),
        .reset       (reset),
        .en_i        (clk_en),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .sclk_o      (dac_sclk)
    );

    // Next-state and datapath: load on acceptance, count bits on SCLK falls,
    // advance DIN on rises, close the frame on the rise after the 16th fall.
    always_comb begin
        state_d     = state_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_fall_d = last_fall_q;
        sync_d      = sync_q;
        ready_d     = ready_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid && ready_q) begin
                    state_d     = SHIFT;
                    sh_a_d      = build_frame(bus.pd, bus.data_a);
                    sh_b_d      = build_frame(bus.pd, bus.data_b);
                    bit_cnt_d   = BIT_CNT_W'(FRAME_W - 1);
                    last_fall_d = 1'b0;
                    sync_d      = 1'b0;
                    ready_d     = 1'b0;
                end
            end

            SHIFT: begin
                // The DAC has just taken the current bit; the counter
                // saturates at 0 and the 16th fall is remembered instead.
                if (fall_tick) begin
                    if (bit_cnt_q == '0) begin
                        last_fall_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end

                if (rise_tick) begin
                    if (last_fall_q) begin
                        state_d   = GAP;
                        sh_a_d    = '0;
                        sh_b_d    = '0;
                        sync_d    = 1'b1;
                        done_d    = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        sh_a_d = {sh_a_q[FRAME_W-2:0], 1'b0};
                        sh_b_d = {sh_b_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d     = IDLE;
                    ready_d     = 1'b1;
                    gap_cnt_d   = '0;
                    last_fall_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                sync_d  = 1'b1;
                ready_d = 1'b1;
                sh_a_d  = '0;
                sh_b_d  = '0;
            end
        endcase
    end

    // State, shift registers and registered outputs; reset aborts any frame.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            last_fall_q <= 1'b0;
            sync_q      <= 1'b1;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_fall_q <= last_fall_d;
            sync_q      <= sync_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign dac_sync  = sync_q;
    assign dac_dina  = sh_a_q[FRAME_W-1];
    assign dac_dinb  = sh_b_q[FRAME_W-1];

endmodule

// File: tb/tb_pmod_dac_tx.sv
// Self-checking bench for pmod_dac_tx at CLK_DIV=2 and CLK_DIV=1.
// Both instances share stimulus; sel chooses which one is observed.
module tb_pmod_dac_tx;

    logic        board_clk = 1'b0;
    logic        reset     = 1'b1;
    logic        valid     = 1'b0;
    logic [11:0] data_a    = '0;
    logic [11:0] data_b    = '0;
    logic [1:0]  pd        = '0;

    int checks = 0;
    int errors = 0;
    int sel    = 0;   // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
    int acc2   = 0;   // frames the bench had accepted by the CLK_DIV=2 instance
    int done2  = 0;   // done pulses seen from the CLK_DIV=2 instance

    always #5 board_clk = ~board_clk;

    pmod_dac_tx_if bus2 ();
    pmod_dac_tx_if bus1 ();

    assign bus2.valid  = valid;
    assign bus2.data_a = data_a;
    assign bus2.data_b = data_b;
    assign bus2.pd     = pd;
    assign bus1.valid  = valid;
    assign bus1.data_a = data_a;
    assign bus1.data_b = data_b;
    assign bus1.pd     = pd;

    logic sync2, sclk2, dina2, dinb2;
    logic sync1, sclk1, dina1, dinb1;

    pmod_dac_tx #(.CLK_DIV(2)) u_dut2 (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus2.slave),
        .dac_sync  (sync2),
        .dac_sclk  (sclk2),
        .dac_dina  (dina2),
        .dac_dinb  (dinb2)
    );

    pmod_dac_tx #(.CLK_DIV(1)) u_dut1 (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus1.slave),
        .dac_sync  (sync1),
        .dac_sclk  (sclk1),
        .dac_dina  (dina1),
        .dac_dinb  (dinb1)
    );

    logic o_ready, o_done, o_sync, o_sclk, o_dina, o_dinb;

    always_comb begin
        o_ready = (sel != 0) ? bus1.ready : bus2.ready;
        o_done  = (sel != 0) ? bus1.done  : bus2.done;
        o_sync  = (sel != 0) ? sync1      : sync2;
        o_sclk  = (sel != 0) ? sclk1      : sclk2;
        o_dina  = (sel != 0) ? dina1      : dina2;
        o_dinb  = (sel != 0) ? dinb1      : dinb2;
    end

    always @(negedge board_clk) if (bus2.done === 1'b1) done2++;

    // Observes one frame whose acceptance edge E0 has just occurred.
    // Expected frame content and timing come from the frame rules:
    // word = {00, pd, data}; falls at (2k+1)H; SYNC low 32H; done at 32H;
    // ready back at 34H. Optional stimulus events are applied at time t.
    task automatic monitor_frame(
        input string       name,
        input logic [11:0] ea, input logic [11:0] eb, input logic [1:0] ep,
        input int          chg_t,
        input logic [11:0] na, input logic [11:0] nb, input logic [1:0] np,
        input int          v_on_t, input int v_off_t
    );
        logic [15:0] exp_a, exp_b, cap_a, cap_b;
        logic        prev_sclk, prev_a, prev_b;
        int h, nfall, fall_bad, sync_lo, done_t, ndone, ready_t, din_bad;
        h = (sel != 0) ? 1 : 2;
        exp_a = {2'b00, ep, ea};
        exp_b = {2'b00, ep, eb};
        cap_a = '0; cap_b = '0;
        prev_sclk = 1'b1; prev_a = 1'b0; prev_b = 1'b0;
        nfall = 0; fall_bad = 0; sync_lo = 0; done_t = -1; ndone = 0;
        ready_t = -1; din_bad = 0;
        for (int t = 0; t < 40 * h + 20; t++) begin
            @(negedge board_clk);
            if (t == chg_t) begin data_a = na; data_b = nb; pd = np; end
            if (t == v_on_t) valid = 1'b1;
            if (t == v_off_t) valid = 1'b0;
            if (o_sync === 1'b0) sync_lo++;
            if (prev_sclk === 1'b1 && o_sclk === 1'b0) begin
                cap_a = {cap_a[14:0], o_dina};
                cap_b = {cap_b[14:0], o_dinb};
                nfall++;
                if (o_sync !== 1'b0 || t != (2 * nfall - 1) * h) fall_bad++;
            end
            if ((o_dina !== prev_a || o_dinb !== prev_b) && o_sclk !== 1'b1) din_bad++;
            if (o_done === 1'b1) begin
                ndone++;
                if (done_t < 0) done_t = t;
            end
            prev_sclk = o_sclk; prev_a = o_dina; prev_b = o_dinb;
            if (o_ready === 1'b1) begin
                ready_t = t;
                break;
            end
        end
        checks++; if (cap_a !== exp_a) begin errors++; $display("FAIL %s dina_frame: got %h want %h", name, cap_a, exp_a); end
        checks++; if (cap_b !== exp_b) begin errors++; $display("FAIL %s dinb_frame: got %h want %h", name, cap_b, exp_b); end
        checks++; if (nfall != 16) begin errors++; $display("FAIL %s fall_count: got %0d want 16", name, nfall); end
        checks++; if (fall_bad != 0) begin errors++; $display("FAIL %s fall_timing: got %0d misplaced want 0", name, fall_bad); end
        checks++; if (sync_lo != 32 * h) begin errors++; $display("FAIL %s sync_low: got %0d want %0d", name, sync_lo, 32 * h); end
        checks++; if (done_t != 32 * h || ndone != 1) begin errors++; $display("FAIL %s done: got t=%0d n=%0d want t=%0d n=1", name, done_t, ndone, 32 * h); end
        checks++; if (ready_t != 34 * h) begin errors++; $display("FAIL %s ready_return: got %0d want %0d", name, ready_t, 34 * h); end
        checks++; if (din_bad != 0) begin errors++; $display("FAIL %s din_change_sclk_low: got %0d want 0", name, din_bad); end
    endtask

    // Waits (bounded) for the observed instance to be ready.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 500) begin
            @(negedge board_clk);
            n++;
        end
        if (o_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s ready_timeout: got %b want 1", name, o_ready);
        end
    endtask

    // Offers one sample pair, then checks the resulting frame.
    task automatic run_frame(input string name, input logic [11:0] a,
                             input logic [11:0] b, input logic [1:0] p);
        wait_ready(name);
        @(negedge board_clk);
        data_a = a; data_b = b; pd = p; valid = 1'b1;
        @(posedge board_clk);
        if (sel == 0) acc2++;
        monitor_frame(name, a, b, p, -1, '0, '0, '0, -1, 0);
    endtask

    task automatic check_idle(input string name);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, o_ready); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", name, o_done); end
        checks++; if (o_sync !== 1'b1) begin errors++; $display("FAIL %s sync: got %b want 1", name, o_sync); end
        checks++; if (o_sclk !== 1'b1) begin errors++; $display("FAIL %s sclk: got %b want 1", name, o_sclk); end
        checks++; if (o_dina !== 1'b0 || o_dinb !== 1'b0) begin errors++; $display("FAIL %s din: got %b%b want 00", name, o_dina, o_dinb); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge board_clk);
        #2;
        check_idle("reset_held");
        @(negedge board_clk);
        reset = 1'b0;
        repeat (4) @(negedge board_clk);
        check_idle("after_release");
    endtask

    task automatic test_single();
        run_frame("single", 12'hA5C, 12'h3F0, 2'b00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("random%0d", i), 12'($urandom), 12'($urandom), 2'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a1, b1, a2, b2;
        logic [1:0]  p1, p2;
        a1 = 12'($urandom); b1 = 12'($urandom); p1 = 2'($urandom);
        a2 = ~a1;           b2 = 12'($urandom); p2 = 2'($urandom);
        wait_ready("b2b");
        @(negedge board_clk);
        data_a = a1; data_b = b1; pd = p1; valid = 1'b1;
        @(posedge board_clk);
        acc2++;
        monitor_frame("b2b_frame1", a1, b1, p1, 10, a2, b2, p2, -1, -1);
        @(posedge board_clk);   // edge E0+34H+1: second acceptance
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_sync !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept_at_69: got ready=%b sync=%b want ready=0 sync=0", o_ready, o_sync);
        end
        acc2++;
        monitor_frame("b2b_frame2", a2, b2, p2, -1, '0, '0, '0, -1, 0);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        wait_ready("midreset");
        @(negedge board_clk);
        data_a = 12'hFFF; data_b = 12'hFFF; pd = 2'b00; valid = 1'b1;
        @(posedge board_clk);
        @(negedge board_clk);   // t=0
        valid = 1'b0;
        repeat (20) @(negedge board_clk);   // t=20
        checks++;
        if (o_sync !== 1'b0 || o_dina !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_inflight: got sync=%b dina=%b ready=%b want 0 1 0", o_sync, o_dina, o_ready);
        end
        #2 reset = 1'b1;
        #1 check_idle("midreset_async");
        @(negedge board_clk);
        reset = 1'b0;
        base = done2;
        acc2 = 0;
        repeat (2) @(negedge board_clk);
        check_idle("midreset_released");
        run_frame("after_reset", 12'h123, 12'h456, 2'b00);
        done2 = done2 - base;
    endtask

    task automatic test_valid_while_busy();
        int extra_done, extra_sync;
        logic [11:0] a, b;
        a = 12'($urandom); b = 12'($urandom);
        wait_ready("busy_pulse");
        @(negedge board_clk);
        data_a = a; data_b = b; pd = 2'b00; valid = 1'b1;
        @(posedge board_clk);
        acc2++;
        monitor_frame("busy_pulse", a, b, 2'b00, -1, '0, '0, '0, 30, 31);
        extra_done = 0; extra_sync = 0;
        repeat (80) begin
            @(negedge board_clk);
            if (o_done === 1'b1) extra_done++;
            if (o_sync === 1'b0) extra_sync++;
        end
        checks++;
        if (extra_done != 0 || extra_sync != 0) begin
            errors++;
            $display("FAIL busy_no_extra_frame: got done=%0d sync_low=%0d want 0 0", extra_done, extra_sync);
        end
        checks++;
        if (done2 != acc2) begin
            errors++;
            $display("FAIL done_vs_accepted: got %0d done want %0d", done2, acc2);
        end
    endtask

    task automatic test_clkdiv1();
        sel = 1;
        run_frame("div1_pd11", 12'hFFF, 12'h000, 2'b11);
        for (int i = 0; i < 3; i++) begin
            run_frame($sformatf("div1_random%0d", i), 12'($urandom), 12'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_valid_while_busy();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
